// File: rtl/time_set_module.sv
// time_set_module: button-driven alarm/time editor with a field-by-field edit FSM.
// Build macro AUTO_REPEAT_EN adds hold-to-repeat stepping on Up/Dn.
module time_set_module #(
  parameter int TIMEOUT       = 50000,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        BtnMode,
  input  logic        BtnUp,
  input  logic        BtnDn,
  input  logic        TSel,
  input  logic [14:0] CT,
  output logic [15:0] ST,
  output logic [1:0]  S,
  output logic [1:0]  CW,
  output logic [1:0]  CW1,
  output logic        CTLoad,
  output logic [14:0] CTNew,
  output logic [2:0]  o_dbg_state
);
  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_DAY  = 3'd1,
    SET_HOUR = 3'd2,
    SET_MIN  = 3'd3,
    SET_ARM  = 3'd4
  } state_t;

  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT);

  state_t      r_state, w_next_state;
  logic [2:0]  r_sync1, r_sync2, r_prev, w_press;
  logic        r_tsel, w_next_tsel;
  logic [15:0] r_buf, w_next_buf, r_alarm, w_next_alarm, r_idle;
  logic        r_ctload, w_next_ctload;
  logic [14:0] r_ctnew, w_next_ctnew;
  logic        w_mode, w_up, w_dn, w_rpt_fire, w_any_press, w_edit;

  // Button bit order everywhere: [0] Mode, [1] Up, [2] Dn.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {BtnDn, BtnUp, BtnMode};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_press = r_sync2 & ~r_prev;
  assign w_edit  = (r_state != RUN);
  assign w_mode  = w_press[0];

`ifdef AUTO_REPEAT_EN
  localparam logic [15:0] RPT_LAST = 16'(REPEAT_CYCLES - 1);
  logic [15:0] r_rpt;
  logic        w_held;
  // Exactly one of Up/Dn held, and not on its initial press cycle.
  assign w_held     = w_edit && (r_sync2[1] ^ r_sync2[2]) && !(w_press[1] || w_press[2]);
  assign w_rpt_fire = w_held && (r_rpt == RPT_LAST);

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr)                    r_rpt <= '0;
    else if (!w_held || w_rpt_fire) r_rpt <= '0;
    else                         r_rpt <= r_rpt + 16'd1;
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  // Mode wins over Up/Dn; Up and Dn together cancel.
  assign w_up = w_edit && !w_mode &&
                ((w_press[1] && !w_press[2]) || (w_rpt_fire && r_sync2[1]));
  assign w_dn = w_edit && !w_mode &&
                ((w_press[2] && !w_press[1]) || (w_rpt_fire && r_sync2[2]));
  assign w_any_press = (|w_press) || w_rpt_fire;

  function automatic logic [2:0] day_step(input logic [2:0] d, input logic up);
    if (d > 3'd6) return 3'd0;
    if (up) return (d == 3'd6) ? 3'd0 : d + 3'd1;
    return (d == 3'd0) ? 3'd6 : d - 3'd1;
  endfunction

  function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
    if (h > 5'd23) return 5'd0;
    if (up) return (h == 5'd23) ? 5'd0 : h + 5'd1;
    return (h == 5'd0) ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [6:0] min_step(input logic [6:0] m, input logic up);
    logic [2:0] t;
    logic [3:0] u;
    t = m[6:4];
    u = m[3:0];
    if (t > 3'd5 || u > 4'd9) return 7'd0;
    if (up) begin
      if (u == 4'd9) begin
        u = 4'd0;
        t = (t == 3'd5) ? 3'd0 : t + 3'd1;
      end else begin
        u = u + 4'd1;
      end
    end else begin
      if (u == 4'd0) begin
        u = 4'd9;
        t = (t == 3'd0) ? 3'd5 : t - 3'd1;
      end else begin
        u = u - 4'd1;
      end
    end
    return {t, u};
  endfunction

  always_comb begin
    w_next_state  = r_state;
    w_next_buf    = r_buf;
    w_next_alarm  = r_alarm;
    w_next_tsel   = r_tsel;
    w_next_ctload = 1'b0;
    w_next_ctnew  = '0;
    case (r_state)
      RUN: if (w_mode) begin
        w_next_tsel  = TSel;
        w_next_buf   = TSel ? {1'b0, CT} : r_alarm;
        w_next_state = SET_DAY;
      end
      SET_DAY: begin
        if (w_mode)             w_next_state = SET_HOUR;
        else if (w_up || w_dn)  w_next_buf[14:12] = day_step(r_buf[14:12], w_up);
      end
      SET_HOUR: begin
        if (w_mode)             w_next_state = SET_MIN;
        else if (w_up || w_dn)  w_next_buf[11:7] = hour_step(r_buf[11:7], w_up);
      end
      SET_MIN: begin
        if (w_mode) begin
          if (r_tsel) begin
            w_next_state  = RUN;
            w_next_ctload = 1'b1;
            w_next_ctnew  = r_buf[14:0];
          end else begin
            w_next_state  = SET_ARM;
          end
        end else if (w_up || w_dn) begin
          w_next_buf[6:0] = min_step(r_buf[6:0], w_up);
        end
      end
      SET_ARM: begin
        if (w_mode) begin
          w_next_alarm = r_buf;
          w_next_state = RUN;
        end else if (w_up || w_dn) begin
          w_next_buf[15] = ~r_buf[15];
        end
      end
      default: w_next_state = RUN;
    endcase
    // Idle abort: no commit, alarm untouched.
    if (w_edit && !w_any_press && r_idle == IDLE_LIMIT) w_next_state = RUN;
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state  <= RUN;
      r_tsel   <= 1'b0;
      r_buf    <= '0;
      r_alarm  <= '0;
      r_ctload <= 1'b0;
      r_ctnew  <= '0;
      r_idle   <= '0;
    end else begin
      r_state  <= w_next_state;
      r_tsel   <= w_next_tsel;
      r_buf    <= w_next_buf;
      r_alarm  <= w_next_alarm;
      r_ctload <= w_next_ctload;
      r_ctnew  <= w_next_ctnew;
      if (!w_edit || w_any_press)   r_idle <= '0;
      else if (r_idle != IDLE_LIMIT) r_idle <= r_idle + 16'd1;
    end
  end

  always_comb begin
    ST  = (r_state == RUN) ? r_alarm : r_buf;
    S   = (r_state == RUN) ? 2'b00 : 2'b10;
    CW  = 2'b00;
    CW1 = 2'b00;
    case (r_state)
      SET_DAY:  CW = 2'b11;
      SET_HOUR: CW = 2'b10;
      SET_MIN:  CW = 2'b01;
      default:  CW = 2'b00;
    endcase
    if (r_state != RUN) CW1 = r_tsel ? 2'b10 : 2'b01;
  end

  assign CTLoad      = r_ctload;
  assign CTNew       = r_ctnew;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_time_set_module.sv
// Self-checking bench for time_set_module: reference model feeds an expected queue per press.
module tb_time_set_module;
  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        btn_mode = 1'b0, btn_up = 1'b0, btn_dn = 1'b0, tsel = 1'b0;
  logic [14:0] ct = '0;

  logic [15:0] st, st_r;
  logic [1:0]  s, cw, cw1, s_r, cw_r, cw1_r;
  logic        ctload, ctload_r;
  logic [14:0] ctnew, ctnew_r;
  logic [2:0]  dbg, dbg_r;

  int total = 0;
  int bad   = 0;
  logic [21:0] exp_q[$];

  // Reference model state
  int          m_state;
  logic        m_tsel;
  logic [15:0] m_buf, m_alarm;

  // CTLoad monitor
  int          ld_cnt = 0, ld_run = 0, ld_last_run = 0, ld_base = 0;
  logic [14:0] ld_val = '0;
  logic [1:0]  ld_s = 2'b11;

`ifdef AUTO_REPEAT_EN
  localparam logic [4:0] EXP_RPT_HOUR = 5'd5;
`else
  localparam logic [4:0] EXP_RPT_HOUR = 5'd1;
`endif

  always #5 clk = ~clk;

  time_set_module #(.TIMEOUT(20), .REPEAT_CYCLES(8)) dut (
    .Clk(clk), .Clr(clr_n), .BtnMode(btn_mode), .BtnUp(btn_up), .BtnDn(btn_dn),
    .TSel(tsel), .CT(ct), .ST(st), .S(s), .CW(cw), .CW1(cw1),
    .CTLoad(ctload), .CTNew(ctnew), .o_dbg_state(dbg)
  );

  // Long timeout so a 40-cycle hold is not aborted.
  time_set_module #(.TIMEOUT(200), .REPEAT_CYCLES(8)) dut_rpt (
    .Clk(clk), .Clr(clr_n), .BtnMode(btn_mode), .BtnUp(btn_up), .BtnDn(btn_dn),
    .TSel(tsel), .CT(ct), .ST(st_r), .S(s_r), .CW(cw_r), .CW1(cw1_r),
    .CTLoad(ctload_r), .CTNew(ctnew_r), .o_dbg_state(dbg_r)
  );

  always @(negedge clk) begin
    if (ctload) begin
      ld_cnt++;
      ld_run++;
      ld_val = ctnew;
      ld_s   = s;
    end else begin
      if (ld_run != 0) ld_last_run = ld_run;
      ld_run = 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_tsel  = 1'b0;
    m_buf   = '0;
    m_alarm = '0;
  endtask

  function automatic logic [21:0] model_word();
    logic [15:0] e_st;
    logic [1:0]  e_s, e_cw, e_cw1;
    e_st  = (m_state == 0) ? m_alarm : m_buf;
    e_s   = (m_state == 0) ? 2'b00 : 2'b10;
    e_cw  = (m_state == 1) ? 2'b11 : (m_state == 2) ? 2'b10 : (m_state == 3) ? 2'b01 : 2'b00;
    e_cw1 = (m_state == 0) ? 2'b00 : (m_tsel ? 2'b10 : 2'b01);
    return {e_st, e_s, e_cw, e_cw1};
  endfunction

  task automatic model_event(input bit m, input bit u, input bit d);
    int dv, hv, tn, un, mv;
    if (m) begin
      case (m_state)
        0: begin
          m_tsel  = tsel;
          m_buf   = tsel ? {1'b0, ct} : m_alarm;
          m_state = 1;
        end
        1: m_state = 2;
        2: m_state = 3;
        3: m_state = m_tsel ? 0 : 4;
        default: begin
          m_alarm = m_buf;
          m_state = 0;
        end
      endcase
    end else if ((u ^ d) && m_state != 0) begin
      case (m_state)
        1: begin
          dv = int'(m_buf[14:12]);
          dv = (dv > 6) ? 0 : (dv + (u ? 1 : 6)) % 7;
          m_buf[14:12] = 3'(dv);
        end
        2: begin
          hv = int'(m_buf[11:7]);
          hv = (hv > 23) ? 0 : (hv + (u ? 1 : 23)) % 24;
          m_buf[11:7] = 5'(hv);
        end
        3: begin
          tn = int'(m_buf[6:4]);
          un = int'(m_buf[3:0]);
          mv = (tn > 5 || un > 9) ? 0 : (tn * 10 + un + (u ? 1 : 59)) % 60;
          m_buf[6:4] = 3'(mv / 10);
          m_buf[3:0] = 4'(mv % 10);
        end
        default: m_buf[15] = ~m_buf[15];
      endcase
    end
  endtask

  // Drive one press (held 4 cycles, then released 4 cycles) and score the settled outputs.
  task automatic press(input bit m, input bit u, input bit d, input string tag);
    logic [21:0] e;
    model_event(m, u, d);
    exp_q.push_back(model_word());
    btn_mode = m;
    btn_up   = u;
    btn_dn   = d;
    repeat (4) @(negedge clk);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_dn   = 1'b0;
    repeat (4) @(negedge clk);
    e = exp_q.pop_front();
    check_val(tag, {10'd0, st, s, cw, cw1}, {10'd0, e});
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_st"}, {16'd0, st}, 32'h0);
    check_val({tag, "_s"}, {30'd0, s}, 32'h0);
    check_val({tag, "_cw"}, {30'd0, cw}, 32'h0);
    check_val({tag, "_cw1"}, {30'd0, cw1}, 32'h0);
    check_val({tag, "_ctload"}, {31'd0, ctload}, 32'h0);
    check_val({tag, "_ctnew"}, {17'd0, ctnew}, 32'h0);
    check_val({tag, "_state"}, {29'd0, dbg}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Clock/reset
    model_reset();
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    check_all_zero("rst");

    // Alarm edit: day 2, hour 23, minutes 59, armed -> 16'hABD9
    tsel = 1'b0;
    press(1, 0, 0, "a_enter");
    press(0, 1, 0, "a_day_up1");
    press(0, 1, 0, "a_day_up2");
    press(1, 0, 0, "a_to_hour");
    press(0, 0, 1, "a_hour_dn");
    press(1, 0, 0, "a_to_min");
    for (int i = 0; i < 59; i++) press(0, 1, 0, "a_min_up");
    press(1, 0, 0, "a_to_arm");
    press(0, 1, 0, "a_arm");
    press(1, 0, 0, "a_commit");
    check_val("alarm_final", {16'd0, st}, 32'h0000ABD9);
    check_val("alarm_no_load", ld_cnt, 0);

    // Simultaneous events
    press(1, 0, 0, "sim_enter");
    press(0, 1, 1, "sim_up_dn");
    check_val("sim_up_dn_buf", {16'd0, st}, 32'h0000ABD9);
    press(1, 1, 0, "sim_mode_up");
    check_val("sim_mode_up_cw", {30'd0, cw}, 32'h2);
    check_val("sim_mode_up_buf", {16'd0, st}, 32'h0000ABD9);

    // Timeout: Up on hour (23 -> 0), then idle
    press(0, 1, 0, "to_up");
    check_val("to_buf", {16'd0, st}, 32'h0000A059);
    repeat (10) @(negedge clk);
    check_val("to_still_edit", {30'd0, s}, 32'h2);
    repeat (10) @(negedge clk);
    m_state = 0;
    check_val("to_s", {30'd0, s}, 32'h0);
    check_val("to_alarm", {16'd0, st}, 32'h0000ABD9);
    check_val("to_no_load", ld_cnt, 0);

    // Time edit: CT = 1A59, minutes 59 -> 00, commit
    ld_base = ld_cnt;
    tsel = 1'b1;
    ct   = 15'h1A59;
    press(1, 0, 0, "t_enter");
    check_val("t_cw1", {30'd0, cw1}, 32'h2);
    press(1, 0, 0, "t_to_hour");
    press(1, 0, 0, "t_to_min");
    press(0, 1, 0, "t_min_up");
    press(1, 0, 0, "t_commit");
    check_val("t_load_cnt", ld_cnt - ld_base, 1);
    check_val("t_load_width", ld_last_run, 1);
    check_val("t_ctnew", {17'd0, ld_val}, 32'h00001A00);
    check_val("t_load_in_run", {30'd0, ld_s}, 32'h0);
    check_val("t_ctnew_after", {17'd0, ctnew}, 32'h0);
    check_val("t_alarm_kept", {16'd0, st}, 32'h0000ABD9);

    // Out-of-range CT fields clamp to 0 on first step
    ld_base = ld_cnt;
    ct = {3'd7, 5'd31, 3'd7, 4'd15};
    press(1, 0, 0, "c_enter");
    press(0, 0, 1, "c_day_dn");
    press(1, 0, 0, "c_to_hour");
    press(0, 1, 0, "c_hour_up");
    press(1, 0, 0, "c_to_min");
    press(0, 0, 1, "c_min_dn");
    press(0, 1, 0, "c_min_up");
    press(1, 0, 0, "c_commit");
    check_val("c_load_cnt", ld_cnt - ld_base, 1);
    check_val("c_ctnew", {17'd0, ld_val}, 32'h00000001);

    // Reset while in SET_HOUR with a modified buffer
    ld_base = ld_cnt;
    tsel = 1'b0;
    press(1, 0, 0, "r_enter");
    press(1, 0, 0, "r_to_hour");
    press(0, 1, 0, "r_hour_up");
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_all_zero("midrst");
    check_val("midrst_no_load", ld_cnt - ld_base, 0);

    // Hold Up 40 cycles in SET_HOUR from hour 0 on the long-timeout instance
    press(1, 0, 0, "h_enter");
    press(1, 0, 0, "h_to_hour");
    btn_up = 1'b1;
    repeat (40) @(negedge clk);
    btn_up = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rpt_hour", {27'd0, st_r[11:7]}, {27'd0, EXP_RPT_HOUR});
    check_val("rpt_state", {29'd0, dbg_r}, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/time_set_module.md
# time_set_module

Button-driven editor that produces the 16-bit set-time word and display-control selects consumed by the display path, and loads new current-time values into the timekeeper. It sits between the debounced front-panel buttons and both the display path and the time counter. It holds the alarm register, runs a field-by-field edit state machine, and writes either the alarm or the current time.

## Interface
- TIMEOUT, 50000: idle cycles in any edit state before abort to RUN (counter width 16).
- REPEAT_CYCLES, 8: hold cycles per auto-repeat step (used only with AUTO_REPEAT_EN).
- Clk  in  1  system clock, rising edge.
- Clr  in  1  asynchronous, active-low reset.
- BtnMode, BtnUp, BtnDn  in  1 each  debounced, level, asynchronous to Clk.
- TSel  in  1  edit target at edit entry: 1 = current time, 0 = alarm.
- CT  in  15  current time {day[2:0], hour[4:0], minTens[2:0], minUnits[3:0]}.
- ST  out  16  {armed, day[2:0], hour[4:0] binary 0–23, minTens[2:0] BCD 0–5, minUnits[3:0] BCD 0–9}.
  - In edit states: edit buffer. In RUN: alarm register.
- S  out  2  display select: 00 in RUN, 10 in any edit state.
- CW  out  2  blinking field: 00 none or arm, 01 minutes, 10 hour, 11 day.
- CW1  out  2  edit target: 00 RUN, 01 alarm edit, 10 time edit.
- CTLoad  out  1  one-cycle strobe to load CTNew into the timekeeper.
- CTNew  out  15  time value to load; valid while CTLoad = 1.

## Operation
- Input path for each button:
  - 2-flop synchronizer, then edge register.
  - A press is a rising edge of the synchronized level.
- States: RUN, SET_DAY, SET_HOUR, SET_MIN, SET_ARM.
- Mode press in RUN:
  - Latches TSel.
  - Loads the buffer: {1'b0, CT} if TSel = 1, otherwise the alarm register.
  - Goes to SET_DAY.
- Mode press advances the state: SET_DAY → SET_HOUR → SET_MIN.
- From SET_MIN:
  - Time target: commit and go to RUN; CTLoad = 1 for one cycle with CTNew = buffer[14:0].
  - Alarm target: go to SET_ARM.
- Mode press in SET_ARM: copy the buffer to the alarm register, go to RUN.
- Field arithmetic (Up = +1, Dn = −1):
  - Day: wraps 6→0 and 0→6.
  - Hour: wraps 23→0 and 0→23.
  - Minutes: BCD. Units 9→0 carries into tens; 59→00; 00→59 on Dn.
  - Arm: Up or Dn toggles bit 15.
- Simultaneous events:
  - Up and Dn pressed in the same cycle: both ignored.
  - Mode with Up or Dn in the same cycle: Mode wins, Up/Dn discarded.
- Up and Dn are ignored in RUN.
- Timeout:
  - The idle counter resets on any press.
  - When it reaches TIMEOUT in an edit state: go to RUN, no commit, alarm register unchanged, no CTLoad.
- Out-of-range buffer values loaded from CT (hour > 23, day 7, minutes > 59) are clamped to 0 on the first Up/Dn applied to that field.

## Timing
- Reset (Clr low), asynchronous:
  - ST = 16'h0000, S = 00, CW = 00, CW1 = 00, CTLoad = 0, CTNew = 0.
  - Alarm register = 0 (disarmed, day 0, 00:00); state = RUN; synchronizers cleared.
- Press latency: outputs update on the 3rd rising Clk edge after the button is first sampled high.
- CTLoad: high for exactly one cycle, coincident with the transition to RUN. CTNew returns to 0 the next cycle.
- Reset mid-edit: the edit is aborted with no commit and no CTLoad; the alarm register returns to 0.
- S, CW and CW1 change in the same cycle as the state change.

## Configuration
- AUTO_REPEAT_EN defined: holding Up or Dn keeps stepping the field.
  - After the initial press, an additional step occurs every REPEAT_CYCLES cycles while the synchronized level stays high.
  - Each repeat step resets the timeout counter.
- AUTO_REPEAT_EN undefined: one step per press only; the repeat counter is not built.

## Test plan
- Reset while in SET_HOUR with Clr low for 2 cycles → all outputs 0, state RUN, alarm 16'h0000, no CTLoad.
- Alarm edit (TSel = 0):
  - Stimulus: Mode; Up×2 (day 2); Mode; Dn×1 (hour 23); Mode; Up×59 (minutes 59, tens/units carry checked); Mode; Up (armed); Mode.
  - Expected: ST = 16'hABD9 in RUN; no CTLoad.
- Time edit (TSel = 1, CT = 15'h1A59):
  - Stimulus: Mode; Mode; Mode; Up (minutes 59→00); Mode.
  - Expected: CTLoad for one cycle with CTNew = 15'h1A00; CW1 = 10 during the edit.
- Simultaneous events:
  - Up and Dn in the same cycle in SET_DAY → buffer unchanged.
  - Mode and Up in the same cycle → state advances, field unchanged.
- Timeout: with TIMEOUT = 20, enter alarm edit, press Up, then idle for 20 cycles → RUN, alarm register unchanged, S = 00.
- Auto-repeat (AUTO_REPEAT_EN, REPEAT_CYCLES = 8): hold Up for 40 cycles in SET_HOUR from 0 → hour = 5 (1 initial step + 4 repeats). Without the macro → hour = 1.
